// File: rtl/move_cursor_ctrl.sv
// Cursor and move-selection controller for a chess board display.
// Five push-buttons are synchronised and edge-detected. The four direction
// buttons auto-repeat while held. The centre button drives an
// IDLE -> SELECTED -> REQUEST selection FSM that hands a move request to the
// game logic and waits for it to be acknowledged.
module move_cursor_ctrl #(
  parameter int unsigned HOLD_CYCLES   = 12500000,
  parameter int unsigned REPEAT_CYCLES = 5000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic         btn_center,
  input  logic [255:0] board,
  input  logic         move_ack,
  input  logic         move_ok,
  output logic [12:0]  moveData,
  output logic         move_req,
  output logic [5:0]   move_from,
  output logic [5:0]   move_to,
  output logic         turn
);

  // Bit positions of the buttons inside the packed button vectors
  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_CENTER = 4;

  // The repeat counter only has to reach the larger of the two intervals
  localparam int unsigned CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int          CNT_W   = $clog2(CNT_MAX + 2);
  localparam logic [CNT_W-1:0] HOLD_T   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] REPEAT_T = CNT_W'(REPEAT_CYCLES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECTED = 2'd1,
    REQUEST  = 2'd2
  } state_t;

  // Moves a 3-bit board coordinate one step, clamping at 0 and 7.
  // Opposing requests in the same cycle cancel out.
  function automatic logic [2:0] sat_step(input logic [2:0] v, input logic inc, input logic dec);
    logic [2:0] r;
    r = v;
    if (inc && !dec && (v != 3'd7)) begin
      r = v + 3'd1;
    end else if (dec && !inc && (v != 3'd0)) begin
      r = v - 3'd1;
    end
    return r;
  endfunction

  // A square holds a piece of the side to move
  function automatic logic own_piece(input logic [3:0] p, input logic side);
    return (p[2:0] != 3'b000) && (p[3] == side);
  endfunction

  logic [4:0] btn_raw;
  logic [4:0] btn_p0;
  logic [4:0] btn_p1;
  logic [4:0] btn_p2;
  logic [4:0] press;

  logic [CNT_W-1:0] rpt_cnt [4];
  logic [3:0]       rpt_phase;
  logic [3:0]       rpt_hit;
  logic [3:0]       dir_ev;
  logic             ctr_ev;

  logic [2:0] let_q, let_d;
  logic [2:0] num_q, num_d;
  logic [5:0] cursor;
  logic [3:0] piece;
  logic       own;

  state_t     state_q, state_d;
  logic [5:0] sel_q, sel_d;
  logic [5:0] from_q, from_d;
  logic [5:0] to_q, to_d;
  logic       turn_q, turn_d;

  assign btn_raw = {btn_center, btn_right, btn_left, btn_down, btn_up};

  // ---- stage p0/p1: two-flop synchroniser, p2: previous level for edge detect
  // Synchronise the raw button levels and keep one extra delayed copy
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_p0 <= '0;
      btn_p1 <= '0;
      btn_p2 <= '0;
    end else begin
      btn_p0 <= btn_raw;
      btn_p1 <= btn_p0;
      btn_p2 <= btn_p1;
    end
  end

  assign press = btn_p1 & ~btn_p2;

  // Repeat fires when the hold counter reaches the interval for its phase
  always_comb begin
    rpt_hit = '0;
    for (int i = 0; i < 4; i++) begin
      rpt_hit[i] = btn_p1[i] & btn_p2[i] &
                   (rpt_cnt[i] == (rpt_phase[i] ? REPEAT_T : HOLD_T));
    end
  end

  // Per-direction hold counters: restart on press and after each repeat,
  // clear as soon as the synchronised level drops
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset || !btn_p1[i]) begin
        rpt_cnt[i]   <= '0;
        rpt_phase[i] <= 1'b0;
      end else if (!btn_p2[i]) begin
        rpt_cnt[i]   <= CNT_W'(1);
        rpt_phase[i] <= 1'b0;
      end else if (rpt_hit[i]) begin
        rpt_cnt[i]   <= CNT_W'(1);
        rpt_phase[i] <= 1'b1;
      end else begin
        rpt_cnt[i]   <= rpt_cnt[i] + CNT_W'(1);
      end
    end
  end

  assign dir_ev = press[3:0] | rpt_hit;
  assign ctr_ev = press[BTN_CENTER];

  // ---- cursor and selection state, updated from the p1/p2 events
  assign cursor = {let_q, num_q};
  assign piece  = board[{cursor, 2'b00} +: 4];
  assign own    = own_piece(piece, turn_q);

  // Cursor moves on direction events except while a request is pending
  always_comb begin
    let_d = let_q;
    num_d = num_q;
    if (state_q != REQUEST) begin
      let_d = sat_step(let_q, dir_ev[BTN_RIGHT], dir_ev[BTN_LEFT]);
      num_d = sat_step(num_q, dir_ev[BTN_DOWN], dir_ev[BTN_UP]);
    end
  end

  // Cursor register
  always_ff @(posedge clk) begin
    if (reset) begin
      let_q <= 3'd0;
      num_q <= 3'd0;
    end else begin
      let_q <= let_d;
      num_q <= num_d;
    end
  end

  // Selection FSM: centre decisions use the cursor before this cycle's move
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    from_d  = from_q;
    to_d    = to_q;
    turn_d  = turn_q;
    case (state_q)
      IDLE: begin
        if (ctr_ev && own) begin
          sel_d   = cursor;
          state_d = SELECTED;
        end
      end
      SELECTED: begin
        if (ctr_ev) begin
          if (cursor == sel_q) begin
            sel_d   = 6'd0;
            state_d = IDLE;
          end else if (own) begin
            sel_d   = cursor;
          end else begin
            from_d  = sel_q;
            to_d    = cursor;
            state_d = REQUEST;
          end
        end
      end
      REQUEST: begin
        if (move_ack) begin
          if (move_ok) begin
            sel_d   = 6'd0;
            turn_d  = ~turn_q;
            state_d = IDLE;
          end else begin
            state_d = SELECTED;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 6'd0;
      from_q  <= 6'd0;
      to_q    <= 6'd0;
      turn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      from_q  <= from_d;
      to_q    <= to_d;
      turn_q  <= turn_d;
    end
  end

  assign moveData  = {(state_q != IDLE), sel_q, let_q, num_q};
  assign move_req  = (state_q == REQUEST);
  assign move_from = from_q;
  assign move_to   = to_q;
  assign turn      = turn_q;

endmodule

// File: tb/tb_move_cursor_ctrl.sv
// Scoreboard bench for move_cursor_ctrl: a driver issues one input vector per
// cycle and pushes the reference model's expected outputs; a monitor pops and
// compares one entry per clock. Directed scenarios run first, then random.
module tb_move_cursor_ctrl;

  localparam int HOLD = 8;
  localparam int REP  = 4;
  localparam int MAXC = 8192;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_center = 1'b0;
  logic [255:0] board = '0;
  logic         move_ack = 1'b0, move_ok = 1'b0;
  logic [12:0]  moveData;
  logic         move_req;
  logic [5:0]   move_from, move_to;
  logic         turn;

  always #5 clk = ~clk;

  move_cursor_ctrl #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_center(btn_center),
    .board(board), .move_ack(move_ack), .move_ok(move_ok),
    .moveData(moveData), .move_req(move_req),
    .move_from(move_from), .move_to(move_to), .turn(turn)
  );

  typedef struct packed {
    logic [12:0] md;
    logic        req;
    logic [5:0]  from;
    logic [5:0]  to;
    logic        trn;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Raw level sampled at each rising edge, per button (0 up,1 down,2 left,3 right,4 centre)
  bit hist [5][MAXC];
  int n_edge = 0;

  // Reference state: cursor file/rank, mode (0 idle,1 selected,2 request)
  int m_let = 0, m_num = 0, m_mode = 0, m_sel = 0, m_from = 0, m_to = 0, m_turn = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // A button produces an event at edge n if it was seen high at edge n-2 after
  // being low at n-3, or, for directions, after HOLD and then every REP edges.
  function automatic bit event_at(input int b, input int n);
    int len;
    int k;
    int held;
    len = 0;
    k = n - 2;
    while (k >= 0 && hist[b][k]) begin
      len++;
      k--;
    end
    if (len == 0) return 1'b0;
    if (len == 1) return 1'b1;
    if (b == 4) return 1'b0;
    held = len - 1;
    if (held == HOLD) return 1'b1;
    if (held > HOLD && ((held - HOLD) % REP) == 0) return 1'b1;
    return 1'b0;
  endfunction

  // Apply one cycle of inputs, advance the model, queue the expectation,
  // and return 2 time units after the rising edge that samples the inputs.
  task automatic drive_cycle(input bit rst, input bit [4:0] btn, input bit ack, input bit ok);
    bit [4:0] ev;
    exp_t e;
    int cur;
    logic [3:0] pc;
    bit own;
    reset = rst;
    {btn_center, btn_right, btn_left, btn_down, btn_up} = btn;
    move_ack = ack;
    move_ok = ok;
    for (int b = 0; b < 5; b++) ev[b] = event_at(b, n_edge);
    for (int b = 0; b < 5; b++) begin
      hist[b][n_edge] = rst ? 1'b0 : btn[b];
      if (rst) begin
        if (n_edge >= 1) hist[b][n_edge-1] = 1'b0;
        if (n_edge >= 2) hist[b][n_edge-2] = 1'b0;
      end
    end
    if (rst) begin
      m_let = 0; m_num = 0; m_mode = 0; m_sel = 0; m_from = 0; m_to = 0; m_turn = 0;
    end else if (m_mode == 2) begin
      if (ack) begin
        if (ok) begin
          m_mode = 0; m_sel = 0; m_turn = 1 - m_turn;
        end else begin
          m_mode = 1;
        end
      end
    end else begin
      cur = m_let * 8 + m_num;
      pc = board[cur*4 +: 4];
      own = (pc[2:0] != 3'b000) && (int'(pc[3]) == m_turn);
      if (ev[4]) begin
        if (m_mode == 0) begin
          if (own) begin m_sel = cur; m_mode = 1; end
        end else if (cur == m_sel) begin
          m_sel = 0; m_mode = 0;
        end else if (own) begin
          m_sel = cur;
        end else begin
          m_from = m_sel; m_to = cur; m_mode = 2;
        end
      end
      if (ev[3] && !ev[2]) m_let = (m_let < 7) ? m_let + 1 : 7;
      if (ev[2] && !ev[3]) m_let = (m_let > 0) ? m_let - 1 : 0;
      if (ev[1] && !ev[0]) m_num = (m_num < 7) ? m_num + 1 : 7;
      if (ev[0] && !ev[1]) m_num = (m_num > 0) ? m_num - 1 : 0;
    end
    n_edge++;
    e.md   = {(m_mode != 0), 6'(m_sel), 3'(m_let), 3'(m_num)};
    e.req  = (m_mode == 2);
    e.from = 6'(m_from);
    e.to   = 6'(m_to);
    e.trn  = 1'(m_turn);
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, 5'b0, 1'b0, 1'b0);
  endtask

  task automatic press(input bit [4:0] m, input int times);
    repeat (times) begin
      drive_cycle(1'b0, m, 1'b0, 1'b0);
      drive_cycle(1'b0, m, 1'b0, 1'b0);
      idle(3);
    end
  endtask

  // Monitor: one expectation per clock, compared just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_moveData", 32'(moveData), 32'(e.md));
        chk("sb_move_req", 32'(move_req), 32'(e.req));
        chk("sb_from_to", 32'({move_from, move_to}), 32'({e.from, e.to}));
        chk("sb_turn", 32'(turn), 32'(e.trn));
      end
    end
  end

  localparam bit [4:0] UP = 5'b00001, DN = 5'b00010, LF = 5'b00100, RT = 5'b01000, CT = 5'b10000;

  initial begin
    bit [4:0] lvl;
    bit pa;
    bit ack;
    bit ok;
    bit rst;
    // Reset state
    drive_cycle(1'b1, 5'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 5'b0, 1'b0, 1'b0);
    idle(1);
    chk("reset_moveData", 32'(moveData), 32'd0);
    chk("reset_req_turn", 32'({move_req, turn, move_from, move_to}), 32'd0);

    // Saturation at 0 and 7
    press(LF, 1);
    press(UP, 1);
    chk("sat_low", 32'(moveData[5:0]), 32'd0);
    press(RT, 9);
    chk("sat_high_let", 32'(moveData[5:3]), 32'd7);
    press(LF, 7);
    chk("back_to_zero", 32'(moveData[5:0]), 32'd0);

    // Auto-repeat: 20-cycle hold gives press + 3 repeats
    repeat (20) drive_cycle(1'b0, DN, 1'b0, 1'b0);
    idle(5);
    chk("repeat_num", 32'(moveData[5:0]), 32'd4);
    press(UP, 3);
    chk("cursor_sq1", 32'(moveData[5:0]), 32'd1);

    // Selection and request
    board = '0;
    board[7:4]   = 4'b0110;
    board[15:12] = 4'b1110;
    press(CT, 1);
    chk("select_sq1", 32'(moveData), 32'(13'b1_000001_000001));
    press(DN, 1);
    press(CT, 1);
    chk("req_raised", 32'(move_req), 32'd1);
    chk("req_from_to", 32'({move_from, move_to}), 32'({6'd1, 6'd2}));
    press(UP | CT, 1);
    chk("req_frozen", 32'(moveData), 32'(13'b1_000001_000010));

    // Rejected then accepted move
    drive_cycle(1'b0, 5'b0, 1'b1, 1'b0);
    idle(2);
    chk("reject_req", 32'(move_req), 32'd0);
    chk("reject_sel", 32'(moveData[12:6]), 32'(7'b1_000001));
    chk("reject_turn", 32'(turn), 32'd0);
    press(CT, 1);
    chk("rereq", 32'(move_req), 32'd1);
    drive_cycle(1'b0, 5'b0, 1'b1, 1'b1);
    idle(2);
    chk("accept_flag", 32'(moveData[12]), 32'd0);
    chk("accept_turn", 32'(turn), 32'd1);
    chk("accept_req", 32'(move_req), 32'd0);

    // IDLE: opponent piece and empty square are ignored
    drive_cycle(1'b1, 5'b0, 1'b0, 1'b0);
    idle(2);
    press(DN, 3);
    press(CT, 1);
    chk("ignore_black", 32'(moveData), 32'd3);
    press(UP, 1);
    press(CT, 1);
    chk("ignore_empty", 32'(moveData), 32'd2);

    // Reset in REQUEST, late ack ignored
    press(UP, 1);
    press(CT, 1);
    chk("sel_again", 32'(moveData[12]), 32'd1);
    press(DN, 1);
    press(CT, 1);
    chk("req_before_rst", 32'(move_req), 32'd1);
    drive_cycle(1'b1, 5'b0, 1'b0, 1'b0);
    chk("rst_in_req", 32'({moveData, move_req, move_from, move_to, turn}), 32'd0);
    idle(1);
    drive_cycle(1'b0, 5'b0, 1'b1, 1'b1);
    idle(2);
    chk("late_ack", 32'({moveData, move_req, move_from, move_to, turn}), 32'd0);

    // Random phase against the reference model
    lvl = '0;
    pa = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) begin
        for (int s = 0; s < 64; s++) begin
          if ($urandom % 2 == 1)
            board[s*4 +: 4] = {1'($urandom % 2), 3'($urandom_range(1, 6))};
          else
            board[s*4 +: 4] = 4'b0000;
        end
      end
      for (int b = 0; b < 4; b++) if ($urandom % 10 == 0) lvl[b] = ~lvl[b];
      if ($urandom % 4 == 0) lvl[4] = ~lvl[4];
      ack = !pa && ($urandom % 5 == 0);
      ok  = 1'($urandom % 2);
      rst = ($urandom % 400 == 0);
      drive_cycle(rst, lvl, ack, ok);
      pa = ack;
    end

    idle(3);
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
